pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/ctl_decode.sv | 86 ++++++++
 rtl/pipe_controller.sv | 82 ++++++++
 tb/tb_pipe_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, R-type functs, ALU control codes and the
// aluop class passed from main decode to ALU decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic       illegal;
        logic [2:0] alucontrol;
    } decode_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alucontrol;
    } e_ctl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } m_ctl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } w_ctl_t;

endpackage

// File: rtl/ctl_decode.sv
// Combinational main decode plus ALU decode for the instruction in Decode.
// Unknown opcodes and unknown R-type functs flag illegal and never write.
module ctl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output decode_t    o_ctl
);

    decode_t    w_main;
    aluop_t     w_aluop;
    logic       w_op_illegal;
    logic       w_funct_illegal;
    logic [2:0] w_alucontrol;

    always_comb begin
        w_main       = '0;
        w_aluop      = ALUOP_ADD;
        w_op_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                w_main.regwrite = 1'b1;
                w_main.regdst   = 1'b1;
                w_aluop         = ALUOP_FUNCT;
            end
            OP_LW: begin
                w_main.regwrite = 1'b1;
                w_main.alusrc   = 1'b1;
                w_main.memtoreg = 1'b1;
            end
            OP_SW: begin
                w_main.alusrc   = 1'b1;
                w_main.memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_main.branch = 1'b1;
                w_aluop       = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_main.regwrite = 1'b1;
                w_main.alusrc   = 1'b1;
            end
            OP_J: begin
                w_main.jump = 1'b1;
            end
            default: begin
                w_op_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_alucontrol    = ALU_ADD;
        w_funct_illegal = 1'b0;
        case (w_aluop)
            ALUOP_ADD: w_alucontrol = ALU_ADD;
            ALUOP_SUB: w_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  w_alucontrol = ALU_ADD;
                    FN_SUB:  w_alucontrol = ALU_SUB;
                    FN_AND:  w_alucontrol = ALU_AND;
                    FN_OR:   w_alucontrol = ALU_OR;
                    FN_SLT:  w_alucontrol = ALU_SLT;
                    default: begin
                        w_alucontrol    = ALU_ADD;
                        w_funct_illegal = 1'b1;
                    end
                endcase
            end
            default: w_alucontrol = ALU_ADD;
        endcase
    end

    always_comb begin
        o_ctl            = w_main;
        o_ctl.alucontrol = w_alucontrol;
        o_ctl.illegal    = w_op_illegal | w_funct_illegal;
        // A bad funct must not reach the register file.
        if (w_funct_illegal) begin
            o_ctl.regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS controller: combinational Decode controls plus the
// D->E, E->M and M->W control registers. flushE bubbles only the E stage.
module pipe_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opD,
    input  logic [5:0] functD,
    input  logic       equalD,
    input  logic       flushE,
    output logic       pcsrcD,
    output logic       branchD,
    output logic       jumpD,
    output logic       illegalD,
    output logic       regwriteE,
    output logic       memtoregE,
    output logic       alusrcE,
    output logic       regdstE,
    output logic [2:0] alucontrolE,
    output logic       regwriteM,
    output logic       memtoregM,
    output logic       memwriteM,
    output logic       regwriteW,
    output logic       memtoregW
);

    decode_t w_dec;
    e_ctl_t  w_e_next;
    e_ctl_t  r_e;
    m_ctl_t  r_m;
    w_ctl_t  r_w;

    ctl_decode u_decode (
        .i_op    (opD),
        .i_funct (functD),
        .o_ctl   (w_dec)
    );

    assign branchD  = w_dec.branch;
    assign jumpD    = w_dec.jump;
    assign illegalD = w_dec.illegal;
    assign pcsrcD   = w_dec.branch & equalD;

    always_comb begin
        w_e_next            = '0;
        w_e_next.regwrite   = w_dec.regwrite;
        w_e_next.memtoreg   = w_dec.memtoreg;
        w_e_next.memwrite   = w_dec.memwrite;
        w_e_next.alusrc     = w_dec.alusrc;
        w_e_next.regdst     = w_dec.regdst;
        w_e_next.alucontrol = w_dec.alucontrol;
    end

    // Reset wins over flush; flush touches only the E register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_e          <= flushE ? '0 : w_e_next;
            r_m.regwrite <= r_e.regwrite;
            r_m.memtoreg <= r_e.memtoreg;
            r_m.memwrite <= r_e.memwrite;
            r_w.regwrite <= r_m.regwrite;
            r_w.memtoreg <= r_m.memtoreg;
        end
    end

    assign regwriteE   = r_e.regwrite;
    assign memtoregE   = r_e.memtoreg;
    assign alusrcE     = r_e.alusrc;
    assign regdstE     = r_e.regdst;
    assign alucontrolE = r_e.alucontrol;
    assign regwriteM   = r_m.regwrite;
    assign memtoregM   = r_m.memtoreg;
    assign memwriteM   = r_m.memwrite;
    assign regwriteW   = r_w.regwrite;
    assign memtoregW   = r_w.memtoreg;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: the driver pushes hand-computed
// expectations tagged with the cycle they are due; a negedge monitor checks them.
module tb_pipe_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opD;
    logic [5:0] functD;
    logic       equalD;
    logic       flushE;
    logic       pcsrcD, branchD, jumpD, illegalD;
    logic       regwriteE, memtoregE, alusrcE, regdstE;
    logic [2:0] alucontrolE;
    logic       regwriteM, memtoregM, memwriteM;
    logic       regwriteW, memtoregW;

    pipe_controller dut (
        .clk         (clk),
        .reset       (reset),
        .opD         (opD),
        .functD      (functD),
        .equalD      (equalD),
        .flushE      (flushE),
        .pcsrcD      (pcsrcD),
        .branchD     (branchD),
        .jumpD       (jumpD),
        .illegalD    (illegalD),
        .regwriteE   (regwriteE),
        .memtoregE   (memtoregE),
        .alusrcE     (alusrcE),
        .regdstE     (regdstE),
        .alucontrolE (alucontrolE),
        .regwriteM   (regwriteM),
        .memtoregM   (memtoregM),
        .memwriteM   (memwriteM),
        .regwriteW   (regwriteW),
        .memtoregW   (memtoregW)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    localparam int S_PCSRCD = 0,  S_BRANCHD = 1,  S_JUMPD = 2,     S_ILLEGALD = 3;
    localparam int S_RWE = 4,     S_M2RE = 5,     S_ALUSRCE = 6,   S_REGDSTE = 7;
    localparam int S_ALUCE = 8,   S_RWM = 9,      S_M2RM = 10,     S_MWM = 11;
    localparam int S_RWW = 12,    S_M2RW = 13;

    typedef struct {
        int         due;
        int         sig;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [2:0] get_sig(input int sig);
        case (sig)
            S_PCSRCD:   return {2'b0, pcsrcD};
            S_BRANCHD:  return {2'b0, branchD};
            S_JUMPD:    return {2'b0, jumpD};
            S_ILLEGALD: return {2'b0, illegalD};
            S_RWE:      return {2'b0, regwriteE};
            S_M2RE:     return {2'b0, memtoregE};
            S_ALUSRCE:  return {2'b0, alusrcE};
            S_REGDSTE:  return {2'b0, regdstE};
            S_ALUCE:    return alucontrolE;
            S_RWM:      return {2'b0, regwriteM};
            S_M2RM:     return {2'b0, memtoregM};
            S_MWM:      return {2'b0, memwriteM};
            S_RWW:      return {2'b0, regwriteW};
            S_M2RW:     return {2'b0, memtoregW};
            default:    return 3'bxxx;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_PCSRCD:   return "pcsrcD";
            S_BRANCHD:  return "branchD";
            S_JUMPD:    return "jumpD";
            S_ILLEGALD: return "illegalD";
            S_RWE:      return "regwriteE";
            S_M2RE:     return "memtoregE";
            S_ALUSRCE:  return "alusrcE";
            S_REGDSTE:  return "regdstE";
            S_ALUCE:    return "alucontrolE";
            S_RWM:      return "regwriteM";
            S_M2RM:     return "memtoregM";
            S_MWM:      return "memwriteM";
            S_RWW:      return "regwriteW";
            S_M2RW:     return "memtoregW";
            default:    return "unknown";
        endcase
    endfunction

    // Scoreboard monitor: compare every entry due in the current cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                logic [2:0] act;
                act = get_sig(exp_q[i].sig);
                n_tests++;
                if (act !== exp_q[i].val) begin
                    n_fail++;
                    $display("[TB] FAIL %s cycle %0d: got %0d expected %0d",
                             sig_name(exp_q[i].sig), cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int offset, input int sig, input logic [2:0] val);
        exp_t e;
        e.due = cyc + offset;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                         input logic fl, input logic rst);
        opD    = op;
        functD = fn;
        equalD = eq;
        flushE = fl;
        reset  = rst;
    endtask

    initial begin
        int budget;
        drive(6'b111111, 6'b000000, 1'b0, 1'b0, 1'b1);

        // Reset held for two edges; check cleared state after the first.
        step();
        expect_at(0, S_RWE, 3'd0);
        expect_at(0, S_RWM, 3'd0);
        expect_at(0, S_MWM, 3'd0);
        expect_at(0, S_RWW, 3'd0);
        step();

        // lw through the whole pipe
        drive(6'b100011, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(0, S_ILLEGALD, 3'd0);
        expect_at(0, S_BRANCHD, 3'd0);
        expect_at(1, S_RWE, 3'd1);
        expect_at(1, S_M2RE, 3'd1);
        expect_at(1, S_ALUSRCE, 3'd1);
        expect_at(1, S_REGDSTE, 3'd0);
        expect_at(1, S_ALUCE, 3'b010);
        expect_at(2, S_M2RM, 3'd1);
        expect_at(2, S_RWM, 3'd1);
        expect_at(2, S_MWM, 3'd0);
        expect_at(3, S_RWW, 3'd1);
        expect_at(3, S_M2RW, 3'd1);
        step();

        // R-type slt then sub
        drive(6'b000000, 6'b101010, 1'b0, 1'b0, 1'b0);
        expect_at(0, S_ILLEGALD, 3'd0);
        expect_at(1, S_ALUCE, 3'b111);
        expect_at(1, S_REGDSTE, 3'd1);
        expect_at(1, S_RWE, 3'd1);
        expect_at(1, S_ALUSRCE, 3'd0);
        step();
        drive(6'b000000, 6'b100010, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_ALUCE, 3'b110);
        expect_at(1, S_REGDSTE, 3'd1);
        expect_at(1, S_RWE, 3'd1);
        step();

        // beq taken, then not taken
        drive(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b0);
        expect_at(0, S_PCSRCD, 3'd1);
        expect_at(0, S_BRANCHD, 3'd1);
        expect_at(1, S_RWE, 3'd0);
        expect_at(1, S_ALUCE, 3'b110);
        expect_at(2, S_RWM, 3'd0);
        expect_at(2, S_MWM, 3'd0);
        step();
        drive(6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(0, S_PCSRCD, 3'd0);
        expect_at(0, S_BRANCHD, 3'd1);
        expect_at(1, S_RWE, 3'd0);
        step();

        // addi followed by a flushed sw; addi must still write back
        drive(6'b001000, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_RWE, 3'd1);
        expect_at(1, S_ALUSRCE, 3'd1);
        expect_at(1, S_REGDSTE, 3'd0);
        expect_at(1, S_ALUCE, 3'b010);
        expect_at(3, S_RWW, 3'd1);
        step();
        drive(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b0);
        expect_at(1, S_ALUSRCE, 3'd0);
        expect_at(1, S_ALUCE, 3'b000);
        expect_at(2, S_MWM, 3'd0);
        expect_at(2, S_RWM, 3'd0);
        step();

        // Unflushed sw reaches M as a write
        drive(6'b101011, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_ALUSRCE, 3'd1);
        expect_at(1, S_RWE, 3'd0);
        expect_at(2, S_MWM, 3'd1);
        expect_at(2, S_RWM, 3'd0);
        step();

        // j
        drive(6'b000010, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(0, S_JUMPD, 3'd1);
        expect_at(0, S_ILLEGALD, 3'd0);
        expect_at(1, S_RWE, 3'd0);
        expect_at(2, S_MWM, 3'd0);
        step();

        // lw, addi, then reset+flush together while lw sits in M
        drive(6'b100011, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_M2RE, 3'd1);
        expect_at(2, S_M2RM, 3'd1);
        expect_at(2, S_RWM, 3'd1);
        step();
        drive(6'b001000, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_RWE, 3'd1);
        step();
        drive(6'b000100, 6'b000000, 1'b1, 1'b1, 1'b1);
        expect_at(0, S_PCSRCD, 3'd1);
        expect_at(1, S_RWE, 3'd0);
        expect_at(1, S_M2RE, 3'd0);
        expect_at(1, S_ALUSRCE, 3'd0);
        expect_at(1, S_REGDSTE, 3'd0);
        expect_at(1, S_ALUCE, 3'b000);
        expect_at(1, S_RWM, 3'd0);
        expect_at(1, S_M2RM, 3'd0);
        expect_at(1, S_MWM, 3'd0);
        expect_at(1, S_RWW, 3'd0);
        expect_at(1, S_M2RW, 3'd0);
        step();

        // First instruction after reset registers immediately
        drive(6'b001000, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_RWE, 3'd1);
        expect_at(3, S_RWW, 3'd1);
        step();

        // Illegal opcode and illegal R-type funct behave as NOPs
        drive(6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0);
        expect_at(0, S_ILLEGALD, 3'd1);
        expect_at(1, S_RWE, 3'd0);
        expect_at(2, S_RWM, 3'd0);
        expect_at(2, S_MWM, 3'd0);
        expect_at(3, S_RWW, 3'd0);
        step();
        drive(6'b000000, 6'b000111, 1'b0, 1'b0, 1'b0);
        expect_at(0, S_ILLEGALD, 3'd1);
        expect_at(1, S_RWE, 3'd0);
        expect_at(1, S_ALUCE, 3'b010);
        expect_at(2, S_RWM, 3'd0);
        expect_at(2, S_MWM, 3'd0);
        expect_at(3, S_RWW, 3'd0);
        step();

        // Remaining ALU functs
        drive(6'b000000, 6'b100100, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_ALUCE, 3'b000);
        expect_at(1, S_RWE, 3'd1);
        step();
        drive(6'b000000, 6'b100101, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_ALUCE, 3'b001);
        expect_at(1, S_RWE, 3'd1);
        step();
        drive(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0);
        expect_at(1, S_ALUCE, 3'b010);
        step();
        drive(6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
